// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared binary16 constants, FSM states and operand classifiers
package fp16_pkg;
    localparam int          EXP_BIAS = 15;
    localparam int          MANT_W   = 10;
    localparam logic [4:0]  EXP_ALL1 = 5'h1F;
    localparam logic [15:0] QNAN     = 16'h7E00;

    typedef enum logic [2:0] {IDLE, MUL, NORM, PACK, FIN} state_t;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == EXP_ALL1) && (x[9:0] != 10'd0);
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:10] == EXP_ALL1) && (x[9:0] == 10'd0);
    endfunction

    function automatic logic is_zero(input logic [15:0] x);
        return x[14:0] == 15'd0;
    endfunction
endpackage

// File: rtl/fp16_mul_exc.sv
// rtl/fp16_mul_exc.sv - combinational special-operand resolver for binary16 multiply
module fp16_mul_exc
    import fp16_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic        o_exc,
    output logic [15:0] o_q,
    output logic        o_inv
);
    logic w_s;
    assign w_s = i_a[15] ^ i_b[15];

    // First match wins; NaNs pass through with their own sign and payload.
    always_comb begin
        o_exc = 1'b0;
        o_q   = 16'h0000;
        o_inv = 1'b0;
        if (is_nan(i_a)) begin
            o_exc = 1'b1;
            o_q   = {i_a[15], EXP_ALL1, i_a[9:0]};
        end else if (is_nan(i_b)) begin
            o_exc = 1'b1;
            o_q   = {i_b[15], EXP_ALL1, i_b[9:0]};
        end else if ((is_inf(i_a) && is_zero(i_b)) || (is_zero(i_a) && is_inf(i_b))) begin
            o_exc = 1'b1;
            o_q   = QNAN;
            o_inv = 1'b1;
        end else if (is_inf(i_a) || is_inf(i_b)) begin
            o_exc = 1'b1;
            o_q   = {w_s, EXP_ALL1, 10'd0};
        end else if (is_zero(i_a) || is_zero(i_b)) begin
            o_exc = 1'b1;
            o_q   = {w_s, 15'd0};
        end
    end
endmodule

// File: rtl/fp16_mul_seq.sv
// rtl/fp16_mul_seq.sv - multi-cycle binary16 multiplier with start/done handshake
module fp16_mul_seq
    import fp16_pkg::*;
#(
    parameter int EXP_BIAS = fp16_pkg::EXP_BIAS,
    parameter int MANT_W   = fp16_pkg::MANT_W
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_p,
    output logic        o_exc,
    output logic        o_inv,
    output logic        o_ovf,
    output logic        o_udf
);
    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [10:0]        r_ma, r_mb;
    logic [21:0]        r_prod;
    logic signed [6:0]  r_e;
    logic               r_sign, r_sticky;
    logic               r_busy, r_done, r_exc, r_inv, r_ovf, r_udf;
    logic [15:0]        r_p;

    logic               w_exc, w_inv;
    logic [15:0]        w_q;
    logic [10:0]        w_ma, w_mb;
    logic [4:0]         w_ea, w_eb;
    logic signed [6:0]  w_e;

    fp16_mul_exc u_exc (.i_a(i_a), .i_b(i_b), .o_exc(w_exc), .o_q(w_q), .o_inv(w_inv));

    // Subnormals: hidden bit 0, exponent treated as 1.
    assign w_ma = {|i_a[14:10], i_a[MANT_W-1:0]};
    assign w_mb = {|i_b[14:10], i_b[MANT_W-1:0]};
    assign w_ea = (i_a[14:10] == 5'd0) ? 5'd1 : i_a[14:10];
    assign w_eb = (i_b[14:10] == 5'd0) ? 5'd1 : i_b[14:10];
    assign w_e  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - $signed(7'(EXP_BIAS));

    logic [4:0] w_shift;
    always_comb begin
        w_shift = 5'd0;
        for (int i = 0; i <= 20; i++) begin
            if (r_prod[i]) w_shift = 5'(20 - i);
        end
    end

    logic              w_rnd;
    logic [11:0]       w_sum;
    logic [9:0]        w_mant;
    logic signed [6:0] w_ep;
    assign w_rnd  = r_prod[9] & ((|r_prod[8:0]) | r_sticky | r_prod[10]);
    assign w_sum  = {1'b0, r_prod[20:10]} + {11'd0, w_rnd};
    // A rounding carry renormalises: mantissa becomes sum[10:1] (all zero) and e+1.
    assign w_mant = w_sum[11] ? w_sum[10:1] : w_sum[9:0];
    assign w_ep   = w_sum[11] ? r_e + 7'sd1 : r_e;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_ma     <= 11'd0;
            r_mb     <= 11'd0;
            r_prod   <= 22'd0;
            r_e      <= 7'sd0;
            r_sign   <= 1'b0;
            r_sticky <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_p      <= 16'h0000;
            r_exc    <= 1'b0;
            r_inv    <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, FIN: begin
                    r_state <= IDLE;
                    if (i_start) begin
                        r_exc <= 1'b0;
                        r_inv <= 1'b0;
                        r_ovf <= 1'b0;
                        r_udf <= 1'b0;
                        if (w_exc) begin
                            r_p     <= w_q;
                            r_exc   <= 1'b1;
                            r_inv   <= w_inv;
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_ma     <= w_ma;
                            r_mb     <= w_mb;
                            r_e      <= w_e;
                            r_sign   <= i_a[15] ^ i_b[15];
                            r_prod   <= 22'd0;
                            r_sticky <= 1'b0;
                            r_cnt    <= 4'd0;
                            r_busy   <= 1'b1;
                            r_state  <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (r_mb[r_cnt]) r_prod <= r_prod + ({11'd0, r_ma} << r_cnt);
                    if (r_cnt == 4'd10) r_state <= NORM;
                    else r_cnt <= r_cnt + 4'd1;
                end
                NORM: begin
                    if (r_prod[21]) begin
                        r_prod   <= r_prod >> 1;
                        r_sticky <= r_prod[0];
                        r_e      <= r_e + 7'sd1;
                    end else begin
                        r_prod <= r_prod << w_shift;
                        r_e    <= r_e - $signed({2'b00, w_shift});
                    end
                    r_state <= PACK;
                end
                PACK: begin
                    if (w_ep >= 7'sd31) begin
                        r_p   <= {r_sign, EXP_ALL1, 10'd0};
                        r_ovf <= 1'b1;
                    end else if (w_ep <= 7'sd0) begin
                        r_p   <= {r_sign, 15'd0};
                        r_udf <= 1'b1;
                    end else begin
                        r_p <= {r_sign, w_ep[4:0], w_mant};
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= FIN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_p    = r_p;
    assign o_exc  = r_exc;
    assign o_inv  = r_inv;
    assign o_ovf  = r_ovf;
    assign o_udf  = r_udf;
endmodule

// File: tb/tb_fp16_mul_seq.sv
// tb/tb_fp16_mul_seq.sv - directed vector bench for fp16_mul_seq
module tb_fp16_mul_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        o_busy, o_done, o_exc, o_inv, o_ovf, o_udf;
    logic [15:0] o_p;

    int total = 0;
    int bad   = 0;

    fp16_mul_seq dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b),
        .o_busy(o_busy), .o_done(o_done), .o_p(o_p),
        .o_exc(o_exc), .o_inv(o_inv), .o_ovf(o_ovf), .o_udf(o_udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at a negedge; returns at the negedge of the DONE cycle.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         output int lat, output int busy_bad);
        a = ta;
        b = tb_v;
        start = 1'b1;
        busy_bad = 0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!o_done && lat < 40) begin
            if (!o_busy) busy_bad++;
            @(negedge clk);
            lat++;
        end
        if (o_busy) busy_bad++;
    endtask

    initial begin
        int lat, bb, cyc, dones;

        vecs[0] = '{16'h3E00, 16'h4000, 16'h4200, 4'b0000, 14};
        vecs[1] = '{16'hC000, 16'h4200, 16'hC600, 4'b0000, 14};
        vecs[2] = '{16'h7C00, 16'h0000, 16'h7E00, 4'b1100, 1};
        vecs[3] = '{16'h7BFF, 16'h4000, 16'h7C00, 4'b0010, 14};
        vecs[4] = '{16'h0400, 16'h0400, 16'h0000, 4'b0001, 14};
        vecs[5] = '{16'h3C01, 16'h3C01, 16'h3C02, 4'b0000, 14};
        vecs[6] = '{16'h3C01, 16'h3E00, 16'h3E02, 4'b0000, 14};
        vecs[7] = '{16'h7E01, 16'h7C00, 16'h7E01, 4'b1000, 1};
        vecs[8] = '{16'h8000, 16'h3C00, 16'h8000, 4'b1000, 1};
        vecs[9] = '{16'h0200, 16'h6400, 16'h2800, 4'b0000, 14};

        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_done", 32'(o_done), 32'd0);
        chk("reset_p", 32'(o_p), 32'd0);
        chk("reset_flags", 32'({o_exc, o_inv, o_ovf, o_udf}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat, bb);
            chk($sformatf("v%0d_p", i), 32'(o_p), 32'(vecs[i].p));
            chk($sformatf("v%0d_flags", i), 32'({o_exc, o_inv, o_ovf, o_udf}), 32'(vecs[i].flags));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_busy", i), 32'(bb), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), 32'(o_done), 32'd0);
            chk($sformatf("v%0d_hold", i), 32'(o_p), 32'(vecs[i].p));
        end

        // START re-pulsed mid-multiply with exception operands must be ignored.
        a = 16'h3E00; b = 16'h4000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!o_done && cyc < 40) begin
            if (cyc == 5) begin
                start = 1'b1; a = 16'h7C00; b = 16'h0000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("repulse_lat", 32'(cyc), 32'd14);
        chk("repulse_p", 32'(o_p), 32'h4200);
        chk("repulse_exc", 32'(o_exc), 32'd0);
        @(negedge clk);

        // Reset in cycle 7 aborts: outputs clear and no DONE follows.
        a = 16'hC000; b = 16'h4200; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 7) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_p", 32'(o_p), 32'd0);
        rst = 1'b0;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        do_op(16'hC000, 16'h4200, lat, bb);
        chk("fresh_p", 32'(o_p), 32'hC600);
        chk("fresh_lat", 32'(lat), 32'd14);
        @(negedge clk);

        // Back-to-back: START held in the DONE cycle is taken on the next edge.
        do_op(16'h7E01, 16'h7C00, lat, bb);
        chk("b2b_first_p", 32'(o_p), 32'h7E01);
        chk("b2b_first_done", 32'(o_done), 32'd1);
        do_op(16'h3C01, 16'h3E00, lat, bb);
        chk("b2b_second_lat", 32'(lat), 32'd14);
        chk("b2b_second_p", 32'(o_p), 32'h3E02);
        chk("b2b_second_flags", 32'({o_exc, o_inv, o_ovf, o_udf}), 32'd0);
        chk("b2b_second_busy", 32'(bb), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
